// File: rtl/hazard_pkg.sv
// Shared encodings, shadow-stage payload and the forwarding-select rule
// for the hazard/forwarding controller.
package hazard_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned RES_W     = 2;
    localparam int unsigned FWD_W     = 2;

    typedef enum logic [RES_W-1:0] {
        RES_ALU  = 2'b00,
        RES_LOAD = 2'b01,
        RES_PC4  = 2'b10
    } result_src_t;

    typedef enum logic [FWD_W-1:0] {
        FWD_RF    = 2'b00,
        FWD_WB    = 2'b01,
        FWD_ALU_M = 2'b10,
        FWD_PC4_M = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic                 reg_write;
        logic [RES_W-1:0]     result_src;
    } stage_ctrl_t;

    localparam stage_ctrl_t STAGE_BUBBLE = '0;

    // Youngest producer wins; a load in M is unreachable and falls to the ALU path.
    function automatic fwd_sel_t fwd_select(input logic [REG_IDX_W-1:0] rs,
                                            input stage_ctrl_t          m,
                                            input stage_ctrl_t          w);
        fwd_sel_t sel;
        sel = FWD_RF;
        if ((rs != '0) && m.reg_write && (rs == m.rd)) begin
            sel = (m.result_src == RES_PC4) ? FWD_PC4_M : FWD_ALU_M;
        end else if ((rs != '0) && w.reg_write && (rs == w.rd)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// One shadow pipeline stage of destination/control fields, with
// synchronous reset and flush-to-bubble.
module hazard_stage_reg
    import hazard_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  stage_ctrl_t d,
    output stage_ctrl_t q
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= STAGE_BUBBLE;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard unit: shadows E/M/W control fields, drives SrcA/SrcB forwarding
// selects, load-use stall/bubble, branch flush and a saturating stall counter.
module hazard_fwd_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_W = REG_IDX_W,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] rs1_d,
    input  logic [REG_W-1:0] rs2_d,
    input  logic [REG_W-1:0] rd_d,
    input  logic             reg_write_d,
    input  logic [1:0]       result_src_d,
    input  logic             pc_src_e,
    output logic [1:0]       forward_a_e,
    output logic [1:0]       forward_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] stall_cnt
);

    stage_ctrl_t          ctrl_d;
    stage_ctrl_t          ctrl_e;
    stage_ctrl_t          ctrl_m;
    stage_ctrl_t          ctrl_w;
    logic [REG_IDX_W-1:0] rs1_dx;
    logic [REG_IDX_W-1:0] rs2_dx;
    logic [REG_IDX_W-1:0] rs1_e;
    logic [REG_IDX_W-1:0] rs2_e;
    logic                 lw_stall_c;
    fwd_sel_t             fwd_a_c;
    fwd_sel_t             fwd_b_c;

    always_comb begin
        rs1_dx            = REG_IDX_W'(rs1_d);
        rs2_dx            = REG_IDX_W'(rs2_d);
        ctrl_d            = STAGE_BUBBLE;
        ctrl_d.rd         = REG_IDX_W'(rd_d);
        ctrl_d.reg_write  = reg_write_d;
        ctrl_d.result_src = result_src_d;
    end

    // E is cleared by flush_e only; a D-stage stall never holds E.
    hazard_stage_reg u_stage_e (
        .clk   (clk),
        .reset (reset),
        .flush (flush_e),
        .d     (ctrl_d),
        .q     (ctrl_e)
    );

    hazard_stage_reg u_stage_m (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .d     (ctrl_e),
        .q     (ctrl_m)
    );

    hazard_stage_reg u_stage_w (
        .clk   (clk),
        .reset (reset),
        .flush (1'b0),
        .d     (ctrl_m),
        .q     (ctrl_w)
    );

    always_ff @(posedge clk) begin
        if (reset || flush_e) begin
            rs1_e <= '0;
            rs2_e <= '0;
        end else begin
            rs1_e <= rs1_dx;
            rs2_e <= rs2_dx;
        end
    end

    always_comb begin
        fwd_a_c    = fwd_select(rs1_e, ctrl_m, ctrl_w);
        fwd_b_c    = fwd_select(rs2_e, ctrl_m, ctrl_w);
        lw_stall_c = (ctrl_e.result_src == RES_LOAD) && ctrl_e.reg_write &&
                     (ctrl_e.rd != '0) &&
                     ((ctrl_e.rd == rs1_dx) || (ctrl_e.rd == rs2_dx));
    end

    // A taken branch discards the wrong-path D instruction instead of holding it.
    assign forward_a_e = fwd_a_c;
    assign forward_b_e = fwd_b_c;
    assign stall_f     = lw_stall_c & ~pc_src_e;
    assign stall_d     = lw_stall_c & ~pc_src_e;
    assign flush_d     = pc_src_e;
    assign flush_e     = lw_stall_c | pc_src_e;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_d && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
